// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-back controller for a 2**AW x DW register file.
// Two requesters share the file's single write port:
//   A = ALU result path, B = memory-load path.
// Each uses a valid/ready handshake. A round-robin pointer resolves contention.
// A pending-write scoreboard holds one bit per register. Decode uses it to
// detect RAW hazards and to refuse WAW reservations.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous, active-low reset
//   a_valid/a_sel/a_data     ALU write-back request
//   a_ready                  ALU request accepted this cycle
//   b_valid/b_sel/b_data     load write-back request
//   b_ready                  load request accepted this cycle
//   rsv_en/rsv_sel           decode reserves a destination register
//   rsv_ok                   reservation of rsv_sel is accepted
//   chk_a/chk_b              decode source registers
//   haz_a/haz_b              source register has a pending write
//   pend                     scoreboard vector, one bit per register
//   wen/selRd/rd             registered regfile write port
//   err                      sticky: a write committed to a non-pending register
module regfile_wb_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [AW-1:0]      a_sel,
  input  logic [DW-1:0]      a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [AW-1:0]      b_sel,
  input  logic [DW-1:0]      b_data,
  output logic               b_ready,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_sel,
  output logic               rsv_ok,
  input  logic [AW-1:0]      chk_a,
  input  logic [AW-1:0]      chk_b,
  output logic               haz_a,
  output logic               haz_b,
  output logic [(2**AW)-1:0] pend,
  output logic               wen,
  output logic [AW-1:0]      selRd,
  output logic [DW-1:0]      rd,
  output logic               err
);

  localparam int NR = 2**AW;

  // Round-robin pointer: 1 means B is preferred on the next contention.
  // It resets to 0, so the first contention after reset goes to A.
  logic          prefer_b;

  logic          grant_a;
  logic          grant_b;
  logic          take;
  logic [AW-1:0] next_sel;
  logic [DW-1:0] next_data;

  logic [NR-1:0] set_mask;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] pend_next;
  logic          commit_err;

  // Arbitration depends only on the valids, the pointer and reset.
  // It never depends on sel, data or the scoreboard, so a requester can
  // compute valid without waiting for ready and no loop can form.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      if (a_valid && b_valid) begin
        grant_a = ~prefer_b;
        grant_b = prefer_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign take    = grant_a | grant_b;

  // Select the winning requester's destination and data.
  always_comb begin
    next_sel  = a_sel;
    next_data = a_data;
    if (grant_b) begin
      next_sel  = b_sel;
      next_data = b_data;
    end
  end

  // Scoreboard update masks.
  // A reservation sets its bit. A committing write (wen high) clears the bit
  // of the register it writes. Set is OR-ed in after the clear, so set wins
  // when both hit the same bit on the same edge.
  // A WAW reservation is refused, and a refused request leaves pend unchanged.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_en && rsv_ok) begin
      set_mask[rsv_sel] = 1'b1;
    end
    if (wen) begin
      clr_mask[selRd] = 1'b1;
    end
    pend_next = (pend & ~clr_mask) | set_mask;
  end

  // A commit to a register that was not pending indicates a decode or
  // requester bug. The write still happens, and the error is only flagged.
  assign commit_err = wen & ~pend[selRd];

  assign rsv_ok = rst & ~pend[rsv_sel];
  assign haz_a  = pend[chk_a];
  assign haz_b  = pend[chk_b];

  // The pointer moves only when a grant is made. It then points away from
  // the winner, so continuous contention alternates A,B,A,B.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefer_b <= 1'b0;
    end else if (grant_a) begin
      prefer_b <= 1'b1;
    end else if (grant_b) begin
      prefer_b <= 1'b0;
    end
  end

  // Registered regfile write port: one cycle from accept to the write edge.
  // selRd/rd hold their values in idle cycles. Only wen drops.
  // Reset discards an accepted write that has not yet committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen   <= 1'b0;
      selRd <= '0;
      rd    <= '0;
    end else begin
      wen <= take;
      if (take) begin
        selRd <= next_sel;
        rd    <= next_data;
      end
    end
  end

  // Scoreboard state and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_next;
      if (commit_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl.
// Every accepted write pushes {sel,data} into a queue. A monitor pops the
// queue when wen appears on the write port. Each scenario task also makes its
// own checks on ready, scoreboard and error outputs.
module tb_regfile_wb_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          a_valid;
  logic [AW-1:0] a_sel;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_sel;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          rsv_en;
  logic [AW-1:0] rsv_sel;
  logic          rsv_ok;
  logic [AW-1:0] chk_a;
  logic [AW-1:0] chk_b;
  logic          haz_a;
  logic          haz_b;
  logic [15:0]   pend;
  logic          wen;
  logic [AW-1:0] selRd;
  logic [DW-1:0] rd;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ok(rsv_ok),
    .chk_a(chk_a), .chk_b(chk_b), .haz_a(haz_a), .haz_b(haz_b),
    .pend(pend), .wen(wen), .selRd(selRd), .rd(rd), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write-port cycle must match the oldest accept.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst && wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got sel=%0d data=%h, required no write", selRd, rd);
      end else begin
        e = exp_q.pop_front();
        if ({selRd, rd} !== e) begin
          errors++;
          $display("[TB] FAIL sb_write: got sel=%0d data=%h, required sel=%0d data=%h",
                   selRd, rd, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic reserve(input logic [AW-1:0] r);
    rsv_en  = 1'b1;
    rsv_sel = r;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsv_ok_r%0d: got %b, required 1", r, rsv_ok);
    end
    @(negedge clk);
    rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_valid = 1'b1; a_sel = 4'd1; a_data = 16'h1234;
    b_valid = 1'b1; b_sel = 4'd2; b_data = 16'h5678;
    rsv_en = 1'b1; rsv_sel = 4'd0; chk_a = 4'd0; chk_b = 4'd0;
    @(negedge clk);
    checks++;
    if ({wen, selRd, rd, pend, err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got wen=%b sel=%0d rd=%h pend=%h err=%b, required all 0",
               wen, selRd, rd, pend, err);
    end
    checks++;
    if ({a_ready, b_ready, rsv_ok} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ready: got a=%b b=%b rsv=%b, required 000", a_ready, b_ready, rsv_ok);
    end
    a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [15:0] exp_pend [5];
    logic [AW-1:0] as [4];
    logic [DW-1:0] ad [4];
    logic [AW-1:0] bs [4];
    logic [DW-1:0] bd [4];
    logic [3:0] av;
    logic [3:0] bv;
    reserve(4'd1); reserve(4'd2); reserve(4'd4); reserve(4'd6);
    checks++;
    if (pend !== 16'h0056) begin
      errors++;
      $display("[TB] FAIL cont_pend_rsv: got %h, required 0056", pend);
    end
    // A,B,A,B grant sequence under continuous contention, then B alone
    exp_a = 4'b0101; exp_b = 4'b1010;
    av = 4'b0111; bv = 4'b1111;
    as = '{4'd1, 4'd4, 4'd4, 4'd0};   ad = '{16'h1111, 16'h4444, 16'h4444, 16'h0000};
    bs = '{4'd2, 4'd2, 4'd6, 4'd6};   bd = '{16'h2222, 16'h2222, 16'h6666, 16'h6666};
    exp_pend = '{16'h0056, 16'h0054, 16'h0050, 16'h0040, 16'h0000};
    for (int c = 0; c < 4; c++) begin
      a_valid = av[c]; a_sel = as[c]; a_data = ad[c];
      b_valid = bv[c]; b_sel = bs[c]; b_data = bd[c];
      #1;
      checks++;
      if ({a_ready, b_ready} !== {exp_a[c], exp_b[c]}) begin
        errors++;
        $display("[TB] FAIL cont_grant_c%0d: got a=%b b=%b, required a=%b b=%b",
                 c, a_ready, b_ready, exp_a[c], exp_b[c]);
      end
      if (exp_a[c]) exp_q.push_back({as[c], ad[c]});
      if (exp_b[c]) exp_q.push_back({bs[c], bd[c]});
      @(negedge clk);
      checks++;
      if (pend !== exp_pend[c]) begin
        errors++;
        $display("[TB] FAIL cont_pend_c%0d: got %h, required %h", c, pend, exp_pend[c]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pend !== exp_pend[4]) begin
      errors++;
      $display("[TB] FAIL cont_pend_end: got %h, required %h", pend, exp_pend[4]);
    end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    reserve(4'd3);
    checks++;
    if (pend !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL single_pend_rsv: got %h, required 0008", pend);
    end
    a_valid = 1'b1; a_sel = 4'd3; a_data = 16'hBEEF;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL single_ready: got a=%b b=%b, required a=1 b=0", a_ready, b_ready);
    end
    exp_q.push_back({4'd3, 16'hBEEF});
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if ({wen, selRd, rd, pend} !== {1'b1, 4'd3, 16'hBEEF, 16'h0008}) begin
      errors++;
      $display("[TB] FAIL single_wport: got wen=%b sel=%0d rd=%h pend=%h, required 1 3 beef 0008",
               wen, selRd, rd, pend);
    end
    @(negedge clk);
    checks++;
    if ({wen, selRd, rd, pend, err} !== {1'b0, 4'd3, 16'hBEEF, 16'h0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_after: got wen=%b sel=%0d rd=%h pend=%h err=%b, required 0 3 beef 0000 0",
               wen, selRd, rd, pend, err);
    end
  endtask

  task automatic test_hazard();
    reserve(4'd5);
    chk_a = 4'd5; chk_b = 4'd0;
    rsv_en = 1'b1; rsv_sel = 4'd5;
    #1;
    checks++;
    if ({haz_a, haz_b, rsv_ok} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL haz_waw: got haz_a=%b haz_b=%b rsv_ok=%b, required 1 0 0", haz_a, haz_b, rsv_ok);
    end
    @(negedge clk);
    rsv_en = 1'b0;
    checks++;
    if (pend !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL haz_pend_keep: got %h, required 0020", pend);
    end
    b_valid = 1'b1; b_sel = 4'd5; b_data = 16'h5555;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL haz_ready: got a=%b b=%b, required a=0 b=1", a_ready, b_ready);
    end
    exp_q.push_back({4'd5, 16'h5555});
    @(negedge clk);
    b_valid = 1'b0;
    checks++;
    if ({wen, haz_a} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL haz_no_bypass: got wen=%b haz_a=%b, required 1 1", wen, haz_a);
    end
    @(negedge clk);
    checks++;
    if ({haz_a, pend} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL haz_clear: got haz_a=%b pend=%h, required 0 0000", haz_a, pend);
    end
  endtask

  task automatic test_unreserved();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unres_err_pre: got %b, required 0", err);
    end
    b_valid = 1'b1; b_sel = 4'd9; b_data = 16'h9999;
    #1;
    exp_q.push_back({4'd9, 16'h9999});
    @(negedge clk);
    b_valid = 1'b0;
    checks++;
    if ({wen, selRd, err} !== {1'b1, 4'd9, 1'b0}) begin
      errors++;
      $display("[TB] FAIL unres_wport: got wen=%b sel=%0d err=%b, required 1 9 0", wen, selRd, err);
    end
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({err, pend} !== {1'b1, 16'h0000}) begin
        errors++;
        $display("[TB] FAIL unres_sticky_%0d: got err=%b pend=%h, required 1 0000", i, err, pend);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midstream_reset();
    reserve(4'd10);
    a_valid = 1'b1; a_sel = 4'd10; a_data = 16'hAAAA;
    #1;
    exp_q.push_back({4'd10, 16'hAAAA});
    @(negedge clk);
    checks++;
    if (wen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mrst_wen_pre: got %b, required 1", wen);
    end
    b_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wen, pend, err, a_ready, b_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL mrst_async: got wen=%b pend=%h err=%b a_rdy=%b b_rdy=%b, required all 0",
               wen, pend, err, a_ready, b_ready);
    end
    exp_q.delete();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wen, pend} !== '0) begin
      errors++;
      $display("[TB] FAIL mrst_lost: got wen=%b pend=%h, required 0 0000", wen, pend);
    end
  endtask

  task automatic test_collision();
    // Unreserved commit to R7 so that a reservation of R7 is accepted
    // on the commit edge itself.
    a_valid = 1'b1; a_sel = 4'd7; a_data = 16'h7777;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coll_ready: got %b, required 1", a_ready);
    end
    exp_q.push_back({4'd7, 16'h7777});
    @(negedge clk);
    a_valid = 1'b0;
    rsv_en = 1'b1; rsv_sel = 4'd7;
    #1;
    checks++;
    if ({wen, selRd, rsv_ok} !== {1'b1, 4'd7, 1'b1}) begin
      errors++;
      $display("[TB] FAIL coll_setup: got wen=%b sel=%0d rsv_ok=%b, required 1 7 1", wen, selRd, rsv_ok);
    end
    @(negedge clk);
    rsv_en = 1'b0;
    checks++;
    if ({pend, err} !== {16'h0080, 1'b1}) begin
      errors++;
      $display("[TB] FAIL coll_set_wins: got pend=%h err=%b, required 0080 1", pend, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_hazard();
    test_unreserved();
    test_midstream_reset();
    test_collision();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
